// File: rtl/axi_rr_slice_arbiter.sv
// -----------------------------------------------------------------------------
// axi_rr_slice_arbiter
//
// Shares one fully-registered AXI-style channel slice among NUM_REQ requesters.
// Requesters are chosen round-robin; once a multi-beat burst starts, the grant
// is locked to that requester until its last beat has been accepted. Accepted
// beats go through a 2-entry (main + skid) register slice, so the downstream
// side sees registered valid/data/last/src and upstream ready is registered.
//
// Ports:
//   aclk         - clock, all state updates on the rising edge
//   areset       - asynchronous active-high reset
//   req_valid_i  - per-requester valid
//   req_last_i   - per-requester last-beat flag
//   req_data_i   - packed payloads, requester i at [i*PAYLOAD_W +: PAYLOAD_W]
//   req_ready_o  - per-requester ready (only the granted requester, only when
//                  the slice has space)
//   out_valid_o  - downstream valid
//   out_data_o   - downstream payload {ID, ADDR, DATA}
//   out_last_o   - downstream last flag
//   out_src_o    - index of the requester that sourced the current beat
//   out_ready_i  - downstream ready
// -----------------------------------------------------------------------------
module axi_rr_slice_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int ID_WIDTH   = 3,
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  localparam int PAYLOAD_W  = ID_WIDTH + ADDR_WIDTH + DATA_WIDTH,
  localparam int SRC_W      = $clog2(NUM_REQ)
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ-1:0]             req_last_i,
  input  logic [NUM_REQ*PAYLOAD_W-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic                           out_valid_o,
  output logic [PAYLOAD_W-1:0]           out_data_o,
  output logic                           out_last_o,
  output logic [SRC_W-1:0]               out_src_o,
  input  logic                           out_ready_i
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [SRC_W-1:0]     lock_id_q, lock_id_d;
  logic [SRC_W-1:0]     last_grant_q, last_grant_d;
  logic                 space_q, space_d;

  logic                 main_valid_q, main_valid_d;
  logic [PAYLOAD_W-1:0] main_data_q, main_data_d;
  logic                 main_last_q, main_last_d;
  logic [SRC_W-1:0]     main_src_q, main_src_d;

  logic                 skid_valid_q, skid_valid_d;
  logic [PAYLOAD_W-1:0] skid_data_q, skid_data_d;
  logic                 skid_last_q, skid_last_d;
  logic [SRC_W-1:0]     skid_src_q, skid_src_d;

  logic                 scan_found;
  logic [SRC_W-1:0]     scan_idx;
  logic [SRC_W-1:0]     sel_idx;
  logic                 grant_any;
  logic [NUM_REQ-1:0]   grant;
  logic                 accept;
  logic                 drain;
  logic [PAYLOAD_W-1:0] in_data;
  logic                 in_last;

  logic [PAYLOAD_W-1:0] req_payload [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_payload[i] = req_data_i[i*PAYLOAD_W +: PAYLOAD_W];
  end

  // Round-robin scan: first valid requester starting just after last_grant,
  // wrapping from NUM_REQ-1 back to 0. The last candidate visited is
  // last_grant itself, so a lone requester can be granted repeatedly.
  always_comb begin : rr_scan
    int unsigned      cand;
    logic [SRC_W-1:0] cand_idx;
    scan_found = 1'b0;
    scan_idx   = '0;
    cand       = '0;
    cand_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (32'(last_grant_q) + 32'(k)) % 32'(NUM_REQ);
      cand_idx = SRC_W'(cand);
      if (!scan_found && req_valid_i[cand_idx]) begin
        scan_found = 1'b1;
        scan_idx   = cand_idx;
      end
    end
  end

  // While locked the grant is pinned to the burst owner even if it drops
  // valid; nobody else may slip a beat into the middle of a burst.
  always_comb begin
    sel_idx   = scan_idx;
    grant_any = scan_found;
    if (state_q == LOCKED) begin
      sel_idx   = lock_id_q;
      grant_any = 1'b1;
    end
    grant = '0;
    if (grant_any) begin
      grant[sel_idx] = 1'b1;
    end
  end

  // Ready comes from a registered space flag so it never depends on the
  // downstream ready combinationally.
  assign req_ready_o = grant & {NUM_REQ{space_q}};
  assign accept      = grant_any & space_q & req_valid_i[sel_idx];
  assign in_data     = req_payload[sel_idx];
  assign in_last     = req_last_i[sel_idx];
  assign drain       = main_valid_q & out_ready_i;

  // Slice occupancy. Since ready is withheld whenever the skid is full, an
  // accepted beat never coincides with a skid-to-main transfer.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_last_d  = main_last_q;
    main_src_d   = main_src_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    skid_src_d   = skid_src_q;

    if (drain) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_last_d  = skid_last_q;
        main_src_d   = skid_src_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) begin
          main_data_d = in_data;
          main_last_d = in_last;
          main_src_d  = sel_idx;
        end
      end
    end else if (accept) begin
      if (!main_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
        main_last_d  = in_last;
        main_src_d   = sel_idx;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
        skid_last_d  = in_last;
        skid_src_d   = sel_idx;
      end
    end

    space_d = ~skid_valid_d;
  end

  // Burst lock FSM. A single-beat transfer in IDLE only advances the
  // round-robin pointer; a non-last beat locks onto its requester.
  always_comb begin
    state_d      = state_q;
    lock_id_d    = lock_id_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_last) begin
            last_grant_d = sel_idx;
          end else begin
            state_d   = LOCKED;
            lock_id_d = sel_idx;
          end
        end
      end
      LOCKED: begin
        if (accept && in_last) begin
          state_d      = IDLE;
          last_grant_d = lock_id_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // space_q resets low so no requester sees ready while reset is asserted;
  // it rises on the first clock edge after release.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= IDLE;
      lock_id_q    <= '0;
      last_grant_q <= SRC_W'(NUM_REQ - 1);
      space_q      <= 1'b0;
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_last_q  <= 1'b0;
      main_src_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      skid_src_q   <= '0;
    end else begin
      state_q      <= state_d;
      lock_id_q    <= lock_id_d;
      last_grant_q <= last_grant_d;
      space_q      <= space_d;
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_last_q  <= main_last_d;
      main_src_q   <= main_src_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      skid_src_q   <= skid_src_d;
    end
  end

  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_data_q;
  assign out_last_o  = main_last_q;
  assign out_src_o   = main_src_q;

endmodule

// File: tb/tb_axi_rr_slice_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_rr_slice_arbiter
//
// Directed bench for axi_rr_slice_arbiter with the default parameters
// (4 requesters, 67-bit payload). Inputs change 1 time unit after the rising
// edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_axi_rr_slice_arbiter;

  localparam int NR = 4;
  localparam int PW = 3 + 32 + 32;

  logic              aclk;
  logic              areset;
  logic [NR-1:0]     req_valid_i;
  logic [NR-1:0]     req_last_i;
  logic [NR*PW-1:0]  req_data_i;
  logic [NR-1:0]     req_ready_o;
  logic              out_valid_o;
  logic [PW-1:0]     out_data_o;
  logic              out_last_o;
  logic [1:0]        out_src_o;
  logic              out_ready_i;

  int n_checks = 0;
  int n_pass   = 0;

  axi_rr_slice_arbiter #(
    .NUM_REQ   (NR),
    .ID_WIDTH  (3),
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .req_valid_i(req_valid_i),
    .req_last_i (req_last_i),
    .req_data_i (req_data_i),
    .req_ready_o(req_ready_o),
    .out_valid_o(out_valid_o),
    .out_data_o (out_data_o),
    .out_last_o (out_last_o),
    .out_src_o  (out_src_o),
    .out_ready_i(out_ready_i)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_inputs();
    req_valid_i = '0;
    req_last_i  = '0;
    req_data_i  = '0;
    out_ready_i = 1'b0;
  endtask

  task automatic set_req(input int r, input logic v, input logic [PW-1:0] p, input logic l);
    req_valid_i[r]         = v;
    req_last_i[r]          = l;
    req_data_i[r*PW +: PW] = p;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    clear_inputs();
    @(negedge aclk);
    areset = 1'b0;
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    clear_inputs();
    req_valid_i = '1;
    req_last_i  = '1;
    out_ready_i = 1'b1;
    @(posedge aclk);
    #1;
    @(negedge aclk);
    n_checks++;
    if (out_valid_o !== 1'b0) $display("[TB] FAIL reset_valid: got %0b expected 0", out_valid_o);
    else n_pass++;
    n_checks++;
    if (out_data_o !== '0) $display("[TB] FAIL reset_data: got %0h expected 0", out_data_o);
    else n_pass++;
    n_checks++;
    if (out_last_o !== 1'b0) $display("[TB] FAIL reset_last: got %0b expected 0", out_last_o);
    else n_pass++;
    n_checks++;
    if (out_src_o !== 2'd0) $display("[TB] FAIL reset_src: got %0d expected 0", out_src_o);
    else n_pass++;
    n_checks++;
    if (req_ready_o !== 4'b0000) $display("[TB] FAIL reset_ready: got %b expected 0000", req_ready_o);
    else n_pass++;
    areset = 1'b0;
    clear_inputs();
    @(posedge aclk);
    #1;
  endtask

  task automatic test_single_beats();
    do_reset();
    out_ready_i = 1'b1;
    for (int b = 0; b < 3; b++) begin
      set_req(0, 1'b1, PW'(b + 1), 1'b1);
      @(negedge aclk);
      n_checks++;
      if (req_ready_o !== 4'b0001) $display("[TB] FAIL single_ready%0d: got %b expected 0001", b, req_ready_o);
      else n_pass++;
      if (b > 0) begin
        n_checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== PW'(b) || out_src_o !== 2'd0)
          $display("[TB] FAIL single_out%0d: got v=%0b d=%0h s=%0d expected v=1 d=%0h s=0",
                   b, out_valid_o, out_data_o, out_src_o, b);
        else n_pass++;
      end
      @(posedge aclk);
      #1;
    end
    set_req(0, 1'b0, '0, 1'b0);
    @(negedge aclk);
    n_checks++;
    if (out_valid_o !== 1'b1 || out_data_o !== PW'(3) || req_ready_o !== 4'b0000)
      $display("[TB] FAIL single_out3: got v=%0b d=%0h r=%b expected v=1 d=3 r=0000",
               out_valid_o, out_data_o, req_ready_o);
    else n_pass++;
    @(posedge aclk);
    #1;
    @(negedge aclk);
    n_checks++;
    if (out_valid_o !== 1'b0) $display("[TB] FAIL single_empty: got %0b expected 0", out_valid_o);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_src;
    do_reset();
    out_ready_i = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, PW'(10 + i), 1'b1);
    for (int c = 0; c < 8; c++) begin
      @(negedge aclk);
      n_checks++;
      if (req_ready_o !== 4'(1 << (c % 4)))
        $display("[TB] FAIL rr_ready%0d: got %b expected %b", c, req_ready_o, 4'(1 << (c % 4)));
      else n_pass++;
      if (c > 0) begin
        exp_src = 2'((c - 1) % 4);
        n_checks++;
        if (out_valid_o !== 1'b1 || out_src_o !== exp_src || out_data_o !== PW'(10 + exp_src))
          $display("[TB] FAIL rr_out%0d: got v=%0b s=%0d d=%0d expected v=1 s=%0d d=%0d",
                   c, out_valid_o, out_src_o, out_data_o, exp_src, 10 + exp_src);
        else n_pass++;
      end
      @(posedge aclk);
      #1;
    end
    clear_inputs();
  endtask

  task automatic test_burst_lock();
    do_reset();
    out_ready_i = 1'b1;
    set_req(2, 1'b1, PW'(30), 1'b1);
    for (int c = 0; c < 4; c++) begin
      set_req(1, 1'b1, PW'(20 + c), (c == 3));
      @(negedge aclk);
      n_checks++;
      if (req_ready_o !== 4'b0010) $display("[TB] FAIL burst_ready%0d: got %b expected 0010", c, req_ready_o);
      else n_pass++;
      if (c > 0) begin
        n_checks++;
        if (out_src_o !== 2'd1 || out_data_o !== PW'(20 + c - 1) || out_last_o !== 1'b0)
          $display("[TB] FAIL burst_out%0d: got s=%0d d=%0d l=%0b expected s=1 d=%0d l=0",
                   c, out_src_o, out_data_o, out_last_o, 20 + c - 1);
        else n_pass++;
      end
      @(posedge aclk);
      #1;
    end
    set_req(1, 1'b0, '0, 1'b0);
    @(negedge aclk);
    n_checks++;
    if (req_ready_o !== 4'b0100 || out_src_o !== 2'd1 || out_data_o !== PW'(23) || out_last_o !== 1'b1)
      $display("[TB] FAIL burst_end: got r=%b s=%0d d=%0d l=%0b expected r=0100 s=1 d=23 l=1",
               req_ready_o, out_src_o, out_data_o, out_last_o);
    else n_pass++;
    @(posedge aclk);
    #1;
    set_req(2, 1'b0, '0, 1'b0);
    @(negedge aclk);
    n_checks++;
    if (out_valid_o !== 1'b1 || out_src_o !== 2'd2 || out_data_o !== PW'(30))
      $display("[TB] FAIL burst_next: got v=%0b s=%0d d=%0d expected v=1 s=2 d=30",
               out_valid_o, out_src_o, out_data_o);
    else n_pass++;
    @(posedge aclk);
    #1;
  endtask

  task automatic test_backpressure();
    int   ordy_tab [9] = '{1, 0, 0, 0, 1, 1, 1, 1, 1};
    int   exp_rdy  [9] = '{1, 1, 0, 0, 0, 1, 1, 0, 0};
    int   exp_val  [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
    int   exp_dat  [9] = '{0, 4, 4, 4, 4, 5, 6, 7, 0};
    int   idx;
    logic rdy_s;
    do_reset();
    idx = 0;
    for (int c = 0; c < 9; c++) begin
      out_ready_i = (ordy_tab[c] != 0);
      if (idx < 4) set_req(0, 1'b1, PW'(4 + idx), 1'b1);
      else set_req(0, 1'b0, '0, 1'b0);
      @(negedge aclk);
      rdy_s = req_ready_o[0];
      n_checks++;
      if (rdy_s !== exp_rdy[c][0]) $display("[TB] FAIL bp_ready%0d: got %0b expected %0d", c, rdy_s, exp_rdy[c]);
      else n_pass++;
      n_checks++;
      if (out_valid_o !== exp_val[c][0]) $display("[TB] FAIL bp_valid%0d: got %0b expected %0d", c, out_valid_o, exp_val[c]);
      else n_pass++;
      if (exp_val[c] != 0) begin
        n_checks++;
        if (out_data_o !== PW'(exp_dat[c])) $display("[TB] FAIL bp_data%0d: got %0d expected %0d", c, out_data_o, exp_dat[c]);
        else n_pass++;
      end
      @(posedge aclk);
      #1;
      if (rdy_s && idx < 4) idx++;
    end
    n_checks++;
    if (idx !== 4) $display("[TB] FAIL bp_accepted: got %0d expected 4", idx);
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready_i = 1'b1;
    set_req(3, 1'b1, PW'(43), 1'b1);
    @(negedge aclk);
    n_checks++;
    if (req_ready_o !== 4'b1000) $display("[TB] FAIL wrap_first: got %b expected 1000", req_ready_o);
    else n_pass++;
    @(posedge aclk);
    #1;
    set_req(0, 1'b1, PW'(40), 1'b1);
    @(negedge aclk);
    n_checks++;
    if (req_ready_o !== 4'b0001) $display("[TB] FAIL wrap_to0: got %b expected 0001", req_ready_o);
    else n_pass++;
    @(posedge aclk);
    #1;
    @(negedge aclk);
    n_checks++;
    if (req_ready_o !== 4'b1000 || out_src_o !== 2'd0 || out_data_o !== PW'(40))
      $display("[TB] FAIL wrap_to3: got r=%b s=%0d d=%0d expected r=1000 s=0 d=40",
               req_ready_o, out_src_o, out_data_o);
    else n_pass++;
    @(posedge aclk);
    #1;
    @(negedge aclk);
    n_checks++;
    if (req_ready_o !== 4'b0001 || out_src_o !== 2'd3 || out_data_o !== PW'(43))
      $display("[TB] FAIL wrap_again: got r=%b s=%0d d=%0d expected r=0001 s=3 d=43",
               req_ready_o, out_src_o, out_data_o);
    else n_pass++;
    @(posedge aclk);
    #1;
    clear_inputs();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    out_ready_i = 1'b0;
    set_req(2, 1'b1, PW'(50), 1'b0);
    @(negedge aclk);
    n_checks++;
    if (req_ready_o !== 4'b0100) $display("[TB] FAIL mid_lock0: got %b expected 0100", req_ready_o);
    else n_pass++;
    @(posedge aclk);
    #1;
    set_req(2, 1'b1, PW'(51), 1'b0);
    @(posedge aclk);
    #1;
    set_req(2, 1'b1, PW'(52), 1'b0);
    set_req(0, 1'b1, PW'(60), 1'b1);
    @(negedge aclk);
    n_checks++;
    if (req_ready_o !== 4'b0000 || out_valid_o !== 1'b1 || out_data_o !== PW'(50) || out_src_o !== 2'd2)
      $display("[TB] FAIL mid_full: got r=%b v=%0b d=%0d s=%0d expected r=0000 v=1 d=50 s=2",
               req_ready_o, out_valid_o, out_data_o, out_src_o);
    else n_pass++;
    #2;
    areset = 1'b1;
    #1;
    n_checks++;
    if (out_valid_o !== 1'b0 || req_ready_o !== 4'b0000 || out_data_o !== '0)
      $display("[TB] FAIL mid_async: got v=%0b r=%b d=%0h expected v=0 r=0000 d=0",
               out_valid_o, req_ready_o, out_data_o);
    else n_pass++;
    set_req(2, 1'b1, PW'(52), 1'b1);
    @(negedge aclk);
    areset = 1'b0;
    @(posedge aclk);
    #1;
    @(negedge aclk);
    n_checks++;
    if (req_ready_o !== 4'b0001 || out_valid_o !== 1'b0)
      $display("[TB] FAIL mid_after: got r=%b v=%0b expected r=0001 v=0", req_ready_o, out_valid_o);
    else n_pass++;
    out_ready_i = 1'b1;
    @(posedge aclk);
    #1;
    set_req(0, 1'b0, '0, 1'b0);
    @(negedge aclk);
    n_checks++;
    if (out_valid_o !== 1'b1 || out_data_o !== PW'(60) || out_src_o !== 2'd0 || req_ready_o !== 4'b0100)
      $display("[TB] FAIL mid_fresh: got v=%0b d=%0d s=%0d r=%b expected v=1 d=60 s=0 r=0100",
               out_valid_o, out_data_o, out_src_o, req_ready_o);
    else n_pass++;
    @(posedge aclk);
    #1;
    clear_inputs();
  endtask

  initial begin
    areset = 1'b1;
    clear_inputs();
    test_reset();
    test_single_beats();
    test_round_robin();
    test_burst_lock();
    test_backpressure();
    test_wrap();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
